// File: rtl/joyride_pkg.sv
// ============================================================================
//  Package     : joyride_pkg
//  Description : Shared obstacle enums, screen constants and LFSR helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package joyride_pkg;

    typedef enum logic [1:0] {
        FLAT     = 2'd0,
        TALL     = 2'd1,
        FALL_TRI = 2'd2,
        RISE_TRI = 2'd3
    } obs_type_t;

    typedef enum logic [1:0] {
        TOP = 2'd0,
        MID = 2'd1,
        BOT = 2'd2
    } obs_pos_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } slot_state_t;

    localparam int X_BIAS   = 100;
    localparam int SCREEN_W = 640;
    localparam int X_W      = 10;

    // Only three lanes exist, so the unused raw encoding folds onto the middle lane.
    function automatic obs_pos_t legal_pos(input logic [1:0] raw);
        return (raw == 2'b11) ? MID : obs_pos_t'(raw);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/obstacle_slot.sv
// ============================================================================
//  Module      : obstacle_slot
//  Description : One obstacle slot: position, shape, lane and flicker phase.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obstacle_slot
    import joyride_pkg::*;
#(
    parameter int FLICK_PERIOD = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic [X_W-1:0] speed,
    input  logic           spawn,
    input  logic [X_W-1:0] spawn_x,
    input  obs_type_t      spawn_type,
    input  obs_pos_t       spawn_pos,
    output logic [X_W-1:0] x,
    output logic [1:0]     obs_type,
    output logic [1:0]     pos,
    output logic           valid,
    output logic           flick,
    output logic           despawn
);

    localparam int                CNT_W    = (FLICK_PERIOD > 1) ? $clog2(FLICK_PERIOD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FLICK_PERIOD - 1);

    slot_state_t      state;
    obs_type_t        type_q;
    obs_pos_t         pos_q;
    logic [CNT_W-1:0] flick_cnt;

    // Leaves the screen when the next step would take x below zero.
    assign despawn  = tick && (state == ACTIVE) && (x < speed);

    assign valid    = (state == ACTIVE);
    assign obs_type = type_q;
    assign pos      = pos_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x         <= '0;
            type_q    <= FLAT;
            pos_q     <= TOP;
            flick     <= 1'b0;
            flick_cnt <= '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (spawn) begin
                        state     <= ACTIVE;
                        x         <= spawn_x;
                        type_q    <= spawn_type;
                        pos_q     <= spawn_pos;
                        flick     <= 1'b0;
                        flick_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (x < speed) begin
                        state     <= IDLE;
                        x         <= '0;
                        type_q    <= FLAT;
                        pos_q     <= TOP;
                        flick     <= 1'b0;
                        flick_cnt <= '0;
                    end else begin
                        x <= x - speed;
                        if (flick_cnt == CNT_LAST) begin
                            flick_cnt <= '0;
                            flick     <= ~flick;
                        end else begin
                            flick_cnt <= flick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/obstacle_scheduler.sv
// ============================================================================
//  Module      : obstacle_scheduler
//  Description : Spawns, scrolls and scores two obstacle slots once per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obstacle_scheduler
    import joyride_pkg::*;
#(
    parameter logic [9:0]  SPAWN_X      = 10'd740,
    parameter int          SPAWN_GAP    = 90,
    parameter int          FLICK_PERIOD = 8,
    parameter int          SPEED_INIT   = 2,
    parameter int          SPEED_MAX    = 6,
    parameter int          RAMP_FRAMES  = 600,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        game_over,
    output logic [9:0]  obs1_x,
    output logic [9:0]  obs2_x,
    output logic [1:0]  obs1_type,
    output logic [1:0]  obs2_type,
    output logic [1:0]  obs1_pos,
    output logic [1:0]  obs2_pos,
    output logic        obs1_valid,
    output logic        obs2_valid,
    output logic        flick1,
    output logic        flick2,
    output logic [15:0] score
);

    localparam logic [15:0]    GAP_LAST   = 16'(SPAWN_GAP - 1);
    localparam logic [15:0]    RAMP_LAST  = 16'(RAMP_FRAMES - 1);
    localparam logic [X_W-1:0] SPEED_RST  = X_W'(SPEED_INIT);
    localparam logic [X_W-1:0] SPEED_TOP  = X_W'(SPEED_MAX);

    logic           frozen;
    logic [15:0]    lfsr;
    logic [15:0]    gap_cnt;
    logic [15:0]    ramp_cnt;
    logic [X_W-1:0] speed;

    logic       advance;
    logic       gap_full;
    logic       spawn_any;
    logic       spawn1;
    logic       spawn2;
    logic       despawn1;
    logic       despawn2;
    logic [1:0] cleared;
    logic [16:0] score_sum;

    obs_type_t  new_type;
    obs_pos_t   new_pos;

    // game_over freezes the same cycle it is seen, so a coincident tick is dropped.
    assign advance   = frame_tick && !frozen && !game_over;
    assign gap_full  = (gap_cnt == GAP_LAST);
    assign spawn_any = advance && gap_full && (!obs1_valid || !obs2_valid);
    assign spawn1    = spawn_any && !obs1_valid;
    assign spawn2    = spawn_any && obs1_valid;

    assign new_type  = obs_type_t'(lfsr[1:0]);
    assign new_pos   = legal_pos(lfsr[3:2]);

    assign cleared   = {1'b0, despawn1} + {1'b0, despawn2};
    assign score_sum = {1'b0, score} + {15'd0, cleared};

    obstacle_slot #(
        .FLICK_PERIOD (FLICK_PERIOD)
    ) u_slot1 (
        .clk        (clk),
        .reset      (reset),
        .tick       (advance),
        .speed      (speed),
        .spawn      (spawn1),
        .spawn_x    (SPAWN_X),
        .spawn_type (new_type),
        .spawn_pos  (new_pos),
        .x          (obs1_x),
        .obs_type   (obs1_type),
        .pos        (obs1_pos),
        .valid      (obs1_valid),
        .flick      (flick1),
        .despawn    (despawn1)
    );

    obstacle_slot #(
        .FLICK_PERIOD (FLICK_PERIOD)
    ) u_slot2 (
        .clk        (clk),
        .reset      (reset),
        .tick       (advance),
        .speed      (speed),
        .spawn      (spawn2),
        .spawn_x    (SPAWN_X),
        .spawn_type (new_type),
        .spawn_pos  (new_pos),
        .x          (obs2_x),
        .obs_type   (obs2_type),
        .pos        (obs2_pos),
        .valid      (obs2_valid),
        .flick      (flick2),
        .despawn    (despawn2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            frozen   <= 1'b0;
            lfsr     <= LFSR_SEED;
            gap_cnt  <= '0;
            ramp_cnt <= '0;
            speed    <= SPEED_RST;
            score    <= '0;
        end else begin
            if (game_over) begin
                frozen <= 1'b1;
            end
            if (advance) begin
                lfsr  <= lfsr_next(lfsr);
                score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];

                // A full gap counter waits here until a slot is free at tick start.
                if (!gap_full) begin
                    gap_cnt <= gap_cnt + 16'd1;
                end else if (spawn_any) begin
                    gap_cnt <= '0;
                end

                if (ramp_cnt == RAMP_LAST) begin
                    ramp_cnt <= '0;
                    if (speed < SPEED_TOP) begin
                        speed <= speed + 1'b1;
                    end
                end else begin
                    ramp_cnt <= ramp_cnt + 16'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
// ============================================================================
//  Module      : tb_obstacle_scheduler
//  Description : Scoreboard bench for obstacle_scheduler against a frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obstacle_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        game_over = 1'b0;
    logic [9:0]  obs1_x, obs2_x;
    logic [1:0]  obs1_type, obs2_type, obs1_pos, obs2_pos;
    logic        obs1_valid, obs2_valid, flick1, flick2;
    logic [15:0] score;

    int tests  = 0;
    int failed = 0;

    obstacle_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .game_over  (game_over),
        .obs1_x     (obs1_x),
        .obs2_x     (obs2_x),
        .obs1_type  (obs1_type),
        .obs2_type  (obs2_type),
        .obs1_pos   (obs1_pos),
        .obs2_pos   (obs2_pos),
        .obs1_valid (obs1_valid),
        .obs2_valid (obs2_valid),
        .flick1     (flick1),
        .flick2     (flick2),
        .score      (score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x1, x2;
        logic [1:0]  t1, t2, p1, p2;
        logic        v1, v2, f1, f2;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    bit          m_v[2];
    int          m_x[2];
    int          m_t[2];
    int          m_p[2];
    bit          m_f[2];
    int          m_fc[2];
    int          m_score, m_gap, m_ramp, m_speed;
    bit          m_frozen;
    logic [15:0] m_lfsr;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 0; m_x[i] = 0; m_t[i] = 0; m_p[i] = 0; m_f[i] = 0; m_fc[i] = 0;
        end
        m_score = 0; m_gap = 0; m_ramp = 0; m_speed = 2; m_frozen = 0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_tick();
        bit old_v0, old_v1;
        int s, p;
        if (m_frozen) return;
        old_v0 = m_v[0];
        old_v1 = m_v[1];
        for (int i = 0; i < 2; i++) begin
            if (m_v[i]) begin
                if (m_x[i] >= m_speed) begin
                    m_x[i] = m_x[i] - m_speed;
                    if (m_fc[i] == 7) begin
                        m_fc[i] = 0;
                        m_f[i]  = !m_f[i];
                    end else begin
                        m_fc[i]++;
                    end
                end else begin
                    m_v[i] = 0; m_x[i] = 0; m_t[i] = 0; m_p[i] = 0; m_f[i] = 0; m_fc[i] = 0;
                    if (m_score < 65535) m_score++;
                end
            end
        end
        if (m_gap == 89) begin
            if (!old_v0 || !old_v1) begin
                s = !old_v0 ? 0 : 1;
                p = int'(m_lfsr[3:2]);
                m_v[s]  = 1;
                m_x[s]  = 740;
                m_t[s]  = int'(m_lfsr[1:0]);
                m_p[s]  = (p == 3) ? 1 : p;
                m_f[s]  = 0;
                m_fc[s] = 0;
                m_gap   = 0;
            end
        end else begin
            m_gap++;
        end
        if (m_ramp == 599) begin
            m_ramp = 0;
            if (m_speed < 6) m_speed++;
        end else begin
            m_ramp++;
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic push_exp();
        exp_t e;
        e.x1 = 10'(m_x[0]); e.x2 = 10'(m_x[1]);
        e.t1 = 2'(m_t[0]);  e.t2 = 2'(m_t[1]);
        e.p1 = 2'(m_p[0]);  e.p2 = 2'(m_p[1]);
        e.v1 = m_v[0];      e.v2 = m_v[1];
        e.f1 = m_f[0];      e.f2 = m_f[1];
        e.sc = 16'(m_score);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
        end
    endtask

    // Monitor: compare one pending expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("obs1_valid", 16'(obs1_valid), 16'(e.v1));
                chk("obs2_valid", 16'(obs2_valid), 16'(e.v2));
                chk("obs1_x",     16'(obs1_x),     16'(e.x1));
                chk("obs2_x",     16'(obs2_x),     16'(e.x2));
                chk("obs1_type",  16'(obs1_type),  16'(e.t1));
                chk("obs2_type",  16'(obs2_type),  16'(e.t2));
                chk("obs1_pos",   16'(obs1_pos),   16'(e.p1));
                chk("obs2_pos",   16'(obs2_pos),   16'(e.p2));
                chk("flick1",     16'(flick1),     16'(e.f1));
                chk("flick2",     16'(flick2),     16'(e.f2));
                chk("score",      score,           e.sc);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        push_exp();
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        model_tick();
        push_exp();
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        push_exp();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Spawns, scrolling, despawn, full-slot gap hold and the full speed ramp.
        for (int n = 1; n <= 3200; n++) begin
            do_tick();
            if (n % 7 == 0) idle_cycle();
        end

        // Reset wins over a coincident tick and game_over mid-movement.
        reset = 1'b1; frame_tick = 1'b1; game_over = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
        model_reset();
        push_exp();

        // First spawn again from the seed, plus early flicker toggles.
        for (int n = 1; n <= 120; n++) do_tick();

        // Freeze: everything holds through 200 ticks.
        game_over = 1'b1;
        @(posedge clk); #1;
        game_over = 1'b0;
        m_frozen = 1;
        push_exp();
        for (int n = 1; n <= 200; n++) do_tick();

        do_reset();
        for (int n = 1; n <= 95; n++) do_tick();

        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 SHALL have parameter SPAWN_X, default 10'd740, meaning spawn obs_x (screen x 640 plus the 100 px off-screen bias).
REQ-002 SHALL have parameter SPAWN_GAP, default 90, meaning the minimum number of frames between spawns.
REQ-003 SHALL have parameter FLICK_PERIOD, default 8, meaning the number of frames per flicker phase.
REQ-004 SHALL have parameters SPEED_INIT (default 2), SPEED_MAX (default 6) and RAMP_FRAMES (default 600), meaning the scroll speed in px/frame and the number of frames per speed step.
REQ-005 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the LFSR reset value; a value of 0 is illegal.
REQ-006 SHALL have clock clk and reset reset (synchronous, active-high).
REQ-007 SHALL have port clk, input, 1 bit: system clock.
REQ-008 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-010 SHALL have port game_over, input, 1 bit: collision flag from the renderer.
REQ-011 SHALL have ports obs1_x and obs2_x, output, 10 bits each: biased horizontal position.
REQ-012 SHALL have ports obs1_type, obs2_type, obs1_pos and obs2_pos, output, 2 bits each.
REQ-013 SHALL have ports obs1_valid and obs2_valid, output, 1 bit each: the slot is active.
REQ-014 SHALL have ports flick1 and flick2, output, 1 bit each: colour phase.
REQ-015 SHALL have port score, output, 16 bits: number of obstacles cleared.

Function
REQ-016 SHALL register all outputs; every update takes effect the cycle after the frame_tick cycle that causes it.
REQ-017 SHALL leave all state unchanged on cycles with frame_tick=0.
REQ-018 SHALL set a sticky frozen flag on any cycle with game_over=1; while frozen, all state is held and frame_tick is ignored.
REQ-019 Per slot, SHALL implement states IDLE/ACTIVE; in IDLE: valid=0, x=0, type=0, pos=0, flick=0.
REQ-020 On a tick while ACTIVE with x >= speed, SHALL compute x <= x - speed.
REQ-021 On a tick while ACTIVE with x < speed, SHALL take the slot to IDLE and increment score, saturating at 16'hFFFF.
REQ-022 On a tick, SHALL increment gap_cnt; when gap_cnt = SPAWN_GAP-1 and a slot is IDLE at the start of the tick, SHALL spawn into the lowest-index IDLE slot and clear gap_cnt.
REQ-023 If both slots are ACTIVE when gap_cnt = SPAWN_GAP-1, SHALL hold gap_cnt at SPAWN_GAP-1 until a slot is free at the start of a tick.
REQ-024 A slot that despawns on a tick SHALL NOT respawn on the same tick; at most one spawn per tick.
REQ-025 Spawn SHALL load x=SPAWN_X, valid=1, flick=0, flick_cnt=0, type=lfsr[1:0], pos=lfsr[3:2], using the LFSR value before that tick's advance.
REQ-026 A spawned pos of 2'b11 SHALL be replaced by 2'b01; pos output 2'b11 never occurs.
REQ-027 LFSR SHALL be a 16-bit Fibonacci register, advanced once per tick: shift left, bit0 = b15^b13^b12^b10.
REQ-028 Per ACTIVE slot, flick_cnt SHALL count ticks modulo FLICK_PERIOD; flick toggles on wrap.
REQ-029 ramp_cnt SHALL count ticks modulo RAMP_FRAMES; on wrap, speed increments if speed < SPEED_MAX.
REQ-030 Speed changes SHALL apply from the tick after the wrap.
REQ-031 All arithmetic SHALL be unsigned; x never wraps below 0.

Reset
REQ-032 Reset SHALL override game_over and frame_tick.
REQ-033 Reset SHALL clear slots to IDLE, outputs to 0, score=0, gap_cnt=0, ramp_cnt=0, frozen=0, speed=SPEED_INIT, lfsr=LFSR_SEED.
REQ-034 Reset asserted mid-movement SHALL produce the reset state the next cycle, with no partial updates.

Structure
REQ-035 SHALL define in shared package joyride_pkg: enum obs_type_t (FLAT=0, TALL=1, FALL_TRI=2, RISE_TRI=3), enum obs_pos_t (TOP=0, MID=1, BOT=2), constants X_BIAS=100 and SCREEN_W=640.
REQ-036 SHALL implement per-slot state (x, type, pos, flick, flick_cnt) in one sub-module, obstacle_slot, instantiated twice; the LFSR, gap, ramp, score and freeze logic are at the top level.

Verification
REQ-037 Reset, then 89 ticks -> both valid=0; on the 90th tick -> obs1_valid=1, obs1_x=740, type/pos match the LFSR reference model, obs2_valid=0.
REQ-038 After the REQ-037 spawn, 10 ticks at speed 2 -> obs1_x=720; flick1 toggles after ticks 8 and 16.
REQ-039 Slot ACTIVE with x=1 and speed=2, one tick -> valid=0, x=0, score increments by 1.
REQ-040 Both slots ACTIVE when gap expires -> no spawn, gap_cnt held; the slot despawning on tick N does not respawn on tick N; spawn occurs on tick N+1.
REQ-041 game_over pulse, then 200 ticks -> all outputs unchanged; reset -> REQ-033 values.
REQ-042 Run 600*5 ticks -> speed reaches 6 and stays there; across 10000 spawns, pos never equals 2'b11.
